serial_sub_ctrl: RTL
====================

Name: serial_sub_ctrl

Overview:
- Bit-serial multi-bit subtractor controller.
- Sequences a single full-subtractor cell over WIDTH bits, LSB first, one bit per clock. Ripples the borrow through an internal borrow flop.
- Computes diff = a - b - borrow_in with a start/busy/done handshake.
- Sits between a requesting master and the existing 1-bit full-subtractor datapath. Trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse/level; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- borrow_in  input  1  initial borrow; captured on accepted start
- busy  output  1  high while an operation is in progress (LOAD or RUN)
- done  output  1  one-cycle pulse when result valid
- diff  output  WIDTH  result; held stable from done until next accepted start
- borrow_out  output  1  final borrow (1 = unsigned underflow); held like diff

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0; done=0; diff=0; borrow_out=0.
  - Internal a_sh, b_sh, bit counter and borrow flop cleared.
  - Reset has priority over every other event, including mid-operation; no done is produced for an aborted operation.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - busy=0. If start=1 at an edge: capture a, b, borrow_in into a_sh, b_sh, br; cnt=0; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - busy=1; one cycle; clears the diff shift register; go to RUN.
  - Operand inputs are not resampled after capture.
- RUN:
  - busy=1. Each cycle, with x=a_sh[0], y=b_sh[0]:
    - d = x^y^br
    - br_next = (~x&y) | (~(x^y)&br)
  - Shift d into diff from the MSB side (diff <= {d, diff[WIDTH-1:1]}).
  - Shift a_sh and b_sh right by 1; br <= br_next; cnt <= cnt+1.
  - When cnt==WIDTH-1, the bit is processed and the state goes to DONE.
- DONE:
  - busy=0; done=1 for exactly one cycle; borrow_out=br.
  - diff now holds the full result; go to IDLE.
- Latency: start accepted at edge N gives done=1 in the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles from acceptance to the done pulse.
- start handling:
  - start while busy or in DONE is ignored; no queueing.
  - start held continuously causes back-to-back operations, with one IDLE cycle between them.
- Outputs diff and borrow_out change only during LOAD/RUN and at reset. Between done and the next accepted start they are stable.
- Width rule: the counter is clog2(WIDTH)+1 bits wide; no wrap occurs within an operation.
- All arithmetic is modulo 2^WIDTH. borrow_out=1 iff a < b + borrow_in as unsigned values.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - Registers two's-complement signed overflow, set in DONE and held like diff: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operand MSBs.
  - The captured MSBs are held in two extra flops.
- Undefined: no ovf port and no extra flops; the port list is exactly as above.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, borrow_in=0, start pulse → busy for 9 cycles (LOAD + 8 RUN), then done pulse 1 cycle. diff=8'h02, borrow_out=0, done at cycle 10 after acceptance.
- a=8'h03, b=8'h05, borrow_in=0 → diff=8'hFE, borrow_out=1.
- a=8'h00, b=8'h00, borrow_in=1 → diff=8'hFF, borrow_out=1.
- Exhaustive check: all 2^17 combinations of (a, b, borrow_in) compared against the reference model {borrow_out, diff} = {1'b0,a} - {1'b0,b} - borrow_in.
- Handshake: start re-asserted at RUN cycle 3 with different operands → ignored. Result matches the first operands, with exactly one done pulse. start held high → done pulses every WIDTH+3 cycles.
- Reset mid-RUN (cycle 4) → next cycle state=IDLE, busy=0, diff=0, borrow_out=0, no done pulse. A following start completes normally.
- With SERIAL_SUB_OVF_EN: a=8'h80, b=8'h01 → diff=8'h7F, ovf=1, borrow_out=0. Then a=8'h7F, b=8'h01 → diff=8'h7E, ovf=0.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor step per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell applied to the current LSBs and the rippled borrow.
    always_comb begin
        x       = a_sh[0];
        y       = b_sh[0];
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
    end

    assign busy = (state == S_LOAD) || (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= borrow_in;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    diff  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                    ovf   <= 1'b0;
`endif
                    state <= S_RUN;
                end
                S_RUN: begin
                    diff <= {d, diff[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // The final bit's d is the result MSB, so borrow and overflow settle here.
                    if (cnt == LAST_BIT) begin
                        borrow_out <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
